// File: rtl/req_encoder_arb_pkg.sv
// Shared types for the request encoder/arbiter: FSM state and selection mode.
package enc_pkg;

    typedef enum logic {
        ENC_IDLE = 1'b0,
        ENC_HOLD = 1'b1
    } enc_state_t;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } enc_mode_t;

endpackage

// File: rtl/req_encoder_arb_prio_sel.sv
// Combinational selector: first set request at or after base, wrapping past N-1.
// Also reports whether any request is set and whether two or more are set.
module prio_sel #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] base_i,
    output logic [W-1:0] idx_o,
    output logic         found_o,
    output logic         multi_o
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;
    logic           hit;
    int             pos;

    // The upper copy of req supplies the wrapped-around candidates below base.
    assign dbl = {req_i, req_i};

    always_comb begin
        masked = dbl;
        for (int j = 0; j < N; j++) begin
            if (j < int'(base_i)) begin
                masked[j] = 1'b0;
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        pos = 0;
        for (int j = 0; j < 2*N; j++) begin
            if (!hit && masked[j]) begin
                hit = 1'b1;
                pos = j;
            end
        end
    end

    assign idx_o   = (pos >= N) ? W'(pos - N) : W'(pos);
    assign found_o = |req_i;
    assign multi_o = |(req_i & (req_i - 1'b1));

endmodule

// File: rtl/req_encoder_arb.sv
// Registered N-way request encoder with fixed-priority or round-robin selection
// and a valid/ready output handshake; every output is driven straight from a flop.
module req_encoder_arb
    import enc_pkg::*;
#(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         multi_hit
);

    enc_state_t   state_q, state_d;
    enc_mode_t    mode_q, mode_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] onehot_q, onehot_d;
    logic         multi_q, multi_d;
    logic         valid_q, valid_d;

    logic         handshake;
    logic         load;
    logic [W-1:0] ptr_adv;
    logic [W-1:0] sel_base;
    logic [W-1:0] sel_idx;
    logic         sel_found;
    logic         sel_multi;

    // The pointer update and the next selection happen in the same cycle, so a
    // back-to-back load already scans from the advanced pointer.
    always_comb begin
        handshake = (state_q == ENC_HOLD) && out_ready;
        ptr_adv   = (idx_q == W'(N - 1)) ? '0 : idx_q + 1'b1;
        ptr_d     = (handshake && mode_q == MODE_RR) ? ptr_adv : ptr_q;
        sel_base  = (enc_mode_t'(mode) == MODE_RR) ? ptr_d : '0;
    end

    prio_sel #(
        .N (N)
    ) u_sel (
        .req_i   (req),
        .base_i  (sel_base),
        .idx_o   (sel_idx),
        .found_o (sel_found),
        .multi_o (sel_multi)
    );

    always_comb begin
        load     = sel_found && ((state_q == ENC_IDLE) || handshake);
        state_d  = state_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        multi_d  = multi_q;
        valid_d  = valid_q;
        if (load) begin
            state_d  = ENC_HOLD;
            mode_d   = enc_mode_t'(mode);
            idx_d    = sel_idx;
            onehot_d = {{(N-1){1'b0}}, 1'b1} << sel_idx;
            multi_d  = sel_multi;
            valid_d  = 1'b1;
        end else if (handshake) begin
            state_d = ENC_IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ENC_IDLE;
            mode_q   <= MODE_FIXED;
            ptr_q    <= '0;
            idx_q    <= '0;
            onehot_q <= '0;
            multi_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            multi_q  <= multi_d;
            valid_q  <= valid_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_idx    = idx_q;
    assign out_onehot = onehot_q;
    assign multi_hit  = multi_q;

endmodule

// File: tb/tb_req_encoder_arb.sv
// Bench for req_encoder_arb: directed steps plus random traffic on N=8 and N=5
// instances, each compared against a rotating-scan reference model.
module tb_req_encoder_arb;

    typedef struct packed {
        logic        valid;
        logic [31:0] idx;
        logic        multi;
        logic [31:0] ptr;
        logic        mode;
    } mdl_t;

    logic       clk;
    logic       rst;
    logic [7:0] req8;
    logic       mode8;
    logic       rdy8;
    logic       valid8;
    logic [2:0] idx8;
    logic [7:0] onehot8;
    logic       multi8;
    logic [4:0] req5;
    logic       mode5;
    logic       rdy5;
    logic       valid5;
    logic [2:0] idx5;
    logic [4:0] onehot5;
    logic       multi5;

    int   checks;
    int   errors;
    mdl_t m8;
    mdl_t m5;

    req_encoder_arb u8 (
        .clk        (clk),
        .rst        (rst),
        .req        (req8),
        .mode       (mode8),
        .out_ready  (rdy8),
        .out_valid  (valid8),
        .out_idx    (idx8),
        .out_onehot (onehot8),
        .multi_hit  (multi8)
    );

    req_encoder_arb #(.N(5)) u5 (
        .clk        (clk),
        .rst        (rst),
        .req        (req5),
        .mode       (mode5),
        .out_ready  (rdy5),
        .out_valid  (valid5),
        .out_idx    (idx5),
        .out_onehot (onehot5),
        .multi_hit  (multi5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First set request scanning base, base+1, ... modulo n.
    function automatic int msel(int n, logic [7:0] r, int base);
        for (int k = 0; k < n; k++) begin
            int i;
            i = (base + k) % n;
            if (r[i]) return i;
        end
        return 0;
    endfunction

    function automatic mdl_t mstep(mdl_t s, int n, logic [7:0] r, logic md, logic rdy);
        mdl_t t;
        logic ld;
        t  = s;
        ld = 1'b0;
        if (!s.valid) begin
            ld = (r != 8'h00);
        end else if (rdy) begin
            if (s.mode) t.ptr = (s.idx + 1) % n;
            if (r != 8'h00) ld = 1'b1;
            else            t.valid = 1'b0;
        end
        if (ld) begin
            t.valid = 1'b1;
            t.mode  = md;
            t.idx   = msel(n, r, md ? int'(t.ptr) : 0);
            t.multi = ($countones(r) >= 2);
        end
        return t;
    endfunction

    function automatic mdl_t mreset();
        mdl_t t;
        t = '0;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive current inputs, advance both models, then compare one edge later.
    task automatic tick();
        m8 = mstep(m8, 8, req8, mode8, rdy8);
        m5 = mstep(m5, 5, {3'b000, req5}, mode5, rdy5);
        @(posedge clk);
        #1;
        chk("v8", 32'(valid8), 32'(m8.valid));
        if (m8.valid) begin
            chk("idx8", 32'(idx8), m8.idx);
            chk("oh8", 32'(onehot8), 32'(8'd1 << m8.idx));
            chk("mh8", 32'(multi8), 32'(m8.multi));
        end
        chk("v5", 32'(valid5), 32'(m5.valid));
        if (m5.valid) begin
            chk("idx5", 32'(idx5), m5.idx);
            chk("oh5", 32'(onehot5), 32'(5'd1 << m5.idx));
            chk("mh5", 32'(multi5), 32'(m5.multi));
        end
    endtask

    initial begin
        int exp_rr[4];
        int exp_np[4];
        checks = 0;
        errors = 0;
        rst   = 1'b1;
        req8  = '0;
        mode8 = 1'b0;
        rdy8  = 1'b0;
        req5  = '0;
        mode5 = 1'b0;
        rdy5  = 1'b0;
        m8    = mreset();
        m5    = mreset();
        #2;
        chk("rst_v", 32'(valid8), 0);
        chk("rst_idx", 32'(idx8), 0);
        chk("rst_oh", 32'(onehot8), 0);
        chk("rst_mh", 32'(multi8), 0);
        #10;
        rst = 1'b0;

        // Legacy single-hot encoding.
        mode8 = 1'b0;
        rdy8  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req8 = 8'd1 << i;
            tick();
            chk("leg_v", 32'(valid8), 1);
            chk("leg_idx", 32'(idx8), i);
            chk("leg_oh", 32'(onehot8), 32'(8'd1 << i));
            chk("leg_mh", 32'(multi8), 0);
        end

        // Fixed priority keeps picking the lowest set bit.
        req8 = 8'b1010_0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fix_idx", 32'(idx8), 2);
            chk("fix_mh", 32'(multi8), 1);
        end

        // Round-robin rotates through the set bits and wraps after 7.
        exp_rr = '{2, 5, 7, 2};
        mode8  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_idx", 32'(idx8), exp_rr[i]);
        end

        // Drain, then hold under backpressure while req changes.
        req8 = 8'h00;
        tick();
        mode8 = 1'b0;
        rdy8  = 1'b0;
        req8  = 8'h10;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_idx", 32'(idx8), 4);
            chk("bp_v", 32'(valid8), 1);
        end
        req8 = 8'h01;
        tick();
        chk("bp_chg_idx", 32'(idx8), 4);
        rdy8 = 1'b1;
        req8 = 8'h00;
        tick();
        chk("bp_drop_v", 32'(valid8), 0);

        // Reach HOLD with idx 5 and ptr 6, then reset between edges.
        mode8 = 1'b1;
        rdy8  = 1'b0;
        req8  = 8'h20;
        tick();
        rdy8 = 1'b1;
        tick();
        chk("pre_rst_idx", 32'(idx8), 5);
        chk("pre_rst_ptr", m8.ptr, 6);
        req8 = 8'h00;
        rdy8 = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_v", 32'(valid8), 0);
        chk("arst_idx", 32'(idx8), 0);
        m8 = mreset();
        m5 = mreset();
        #2;
        rst  = 1'b0;
        req8 = 8'hFF;
        tick();
        chk("post_rst_idx", 32'(idx8), 0);

        // Non-power-of-two instance: round-robin over bits 0 and 4.
        req8  = 8'h00;
        rdy8  = 1'b1;
        tick();
        exp_np = '{0, 4, 0, 4};
        mode5  = 1'b1;
        rdy5   = 1'b1;
        req5   = 5'b10001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("np_idx", 32'(idx5), exp_np[i]);
        end

        // Random traffic on both instances.
        for (int c = 0; c < 400; c++) begin
            req8  = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
            mode8 = 1'($urandom);
            rdy8  = ($urandom_range(9) < 7);
            req5  = ($urandom_range(3) == 0) ? 5'h00 : 5'($urandom);
            mode5 = 1'($urandom);
            rdy5  = ($urandom_range(9) < 7);
            tick();
            if (valid5) chk("np_range", 32'(idx5 < 3'd5), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
